// File: rtl/traffic_sensor_cond_pkg.sv
// Shared definitions for the vehicle-loop conditioner: channel state encodings,
// default timing parameters and the counter-width helper.
package traffic_sensor_cond_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_OCC  = 2'b01;
  localparam logic [1:0] ST_HOLD = 2'b10;

  localparam int unsigned DB_CYC_DEF   = 4;
  localparam int unsigned HOLD_CYC_DEF = 8;
  localparam int unsigned CNT_W_DEF    = 8;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : 32'($clog2(n));
  endfunction

endpackage

// File: rtl/traffic_sensor_chan.sv
// One detector channel: 2-flop synchroniser, debounce, occupancy FSM with
// hold-off stretch, and a saturating arrival counter.
module traffic_sensor_chan
  import traffic_sensor_cond_pkg::*;
#(
  parameter int unsigned DB_CYC   = DB_CYC_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_raw,
  input  logic             i_clr,
  output logic             o_t,
  output logic [CNT_W-1:0] o_cnt
);

  localparam int unsigned DCNT_W = cnt_width(DB_CYC);
  localparam int unsigned HCNT_W = cnt_width(HOLD_CYC);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DB_CYC - 1);
  // Only used when HOLD_CYC > 0, so the wrap at HOLD_CYC == 0 is harmless.
  localparam logic [HCNT_W-1:0] HCNT_LOAD = HCNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  logic              r_s1;
  logic              r_s2;
  logic              r_deb;
  logic [DCNT_W-1:0] r_dcnt;
  logic [1:0]        r_state;
  logic [HCNT_W-1:0] r_hcnt;
  logic              r_t;
  logic [CNT_W-1:0]  r_cnt;

  logic [1:0]        w_state_nxt;
  logic [HCNT_W-1:0] w_hcnt_nxt;
  logic [CNT_W-1:0]  w_cnt_base;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_arrive;

  // Synchroniser and debounce: a level is accepted after DB_CYC stable samples.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_deb  <= 1'b0;
      r_dcnt <= '0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_dcnt <= '0;
      end else if (r_dcnt == DCNT_LAST) begin
        r_deb  <= r_s2;
        r_dcnt <= '0;
      end else begin
        r_dcnt <= r_dcnt + DCNT_W'(1);
      end
    end
  end

  // Occupancy FSM next state, hold countdown and arrival counting.
  always_comb begin
    w_state_nxt = r_state;
    w_hcnt_nxt  = r_hcnt;
    w_cnt_base  = r_cnt;
    w_cnt_nxt   = r_cnt;
    w_arrive    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_deb) w_state_nxt = ST_OCC;
      end
      ST_OCC: begin
        if (!r_deb) begin
          if (HOLD_CYC > 0) begin
            w_state_nxt = ST_HOLD;
            w_hcnt_nxt  = HCNT_LOAD;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_HOLD: begin
        if (r_deb) begin
          w_state_nxt = ST_OCC;
        end else if (r_hcnt == '0) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_hcnt_nxt = r_hcnt - HCNT_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_arrive   = (w_state_nxt == ST_OCC) && (r_state != ST_OCC);
    // Clear takes effect first so a same-cycle arrival still counts.
    w_cnt_base = i_clr ? '0 : r_cnt;
    w_cnt_nxt  = (w_arrive && (w_cnt_base != CNT_MAX)) ? w_cnt_base + CNT_W'(1) : w_cnt_base;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_hcnt  <= '0;
      r_t     <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_t     <= (w_state_nxt != ST_IDLE);
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign o_t   = r_t;
  assign o_cnt = r_cnt;

endmodule

// File: rtl/traffic_sensor_cond.sv
// Conditions the two raw loop-detector inputs into the TA/TB traffic-present
// flags and per-street arrival counts for the light controller.
module traffic_sensor_cond
  import traffic_sensor_cond_pkg::*;
#(
  parameter int unsigned DB_CYC   = DB_CYC_DEF,
  parameter int unsigned HOLD_CYC = HOLD_CYC_DEF,
  parameter int unsigned CNT_W    = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             RESETB,
  input  logic             RAW_A,
  input  logic             RAW_B,
  input  logic             CLR_A,
  input  logic             CLR_B,
  output logic             TA,
  output logic             TB,
  output logic [CNT_W-1:0] CNT_A,
  output logic [CNT_W-1:0] CNT_B
);

  traffic_sensor_chan #(
    .DB_CYC  (DB_CYC),
    .HOLD_CYC(HOLD_CYC),
    .CNT_W   (CNT_W)
  ) u_chan_a (
    .clk  (CLK),
    .rst_n(RESETB),
    .i_raw(RAW_A),
    .i_clr(CLR_A),
    .o_t  (TA),
    .o_cnt(CNT_A)
  );

  traffic_sensor_chan #(
    .DB_CYC  (DB_CYC),
    .HOLD_CYC(HOLD_CYC),
    .CNT_W   (CNT_W)
  ) u_chan_b (
    .clk  (CLK),
    .rst_n(RESETB),
    .i_raw(RAW_B),
    .i_clr(CLR_B),
    .o_t  (TB),
    .o_cnt(CNT_B)
  );

endmodule

// File: tb/tb_traffic_sensor_cond.sv
// Bench for traffic_sensor_cond: hand-derived vector table, async reset corner,
// and randomized traffic against a window-based reference model.
module tb_traffic_sensor_cond;

  localparam int unsigned DB   = 4;
  localparam int unsigned HOLD = 8;
  localparam int unsigned CW   = 2;
  localparam int          CMAX = (1 << CW) - 1;

  logic          clk;
  logic          rst_n;
  logic          raw_a, raw_b, clr_a, clr_b;
  logic          ta, tb;
  logic [CW-1:0] cnt_a, cnt_b;

  int n_chk = 0;
  int n_err = 0;

  traffic_sensor_cond #(
    .DB_CYC  (DB),
    .HOLD_CYC(HOLD),
    .CNT_W   (CW)
  ) dut (
    .CLK   (clk),
    .RESETB(rst_n),
    .RAW_A (raw_a),
    .RAW_B (raw_b),
    .CLR_A (clr_a),
    .CLR_B (clr_b),
    .TA    (ta),
    .TB    (tb),
    .CNT_A (cnt_a),
    .CNT_B (cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: per-edge history of raw samples and accepted levels.
  // Bit k of each vector is the value k edges ago.
  bit [15:0] m_raw [2];
  bit [15:0] m_deb [2];
  bit        m_t   [2];
  int        m_cnt [2];

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_raw[c] = '0;
      m_deb[c] = '0;
      m_t[c]   = 1'b0;
      m_cnt[c] = 0;
    end
  endtask

  task automatic model_step(input int c, input bit raw, input bit clr);
    bit [15:0] rh;
    bit        all1, all0, d;
    rh   = {m_raw[c][14:0], raw};
    all1 = 1'b1;
    all0 = 1'b1;
    // Synchronised value at edge n-j is the raw sample of edge n-j-1.
    for (int k = 2; k <= int'(DB) + 1; k++) begin
      if (!rh[k]) all1 = 1'b0;
      if (rh[k])  all0 = 1'b0;
    end
    d = m_deb[c][0];
    if (all1) d = 1'b1;
    else if (all0) d = 1'b0;
    m_raw[c] = rh;
    m_deb[c] = {m_deb[c][14:0], d};
    m_t[c] = 1'b0;
    for (int k = 1; k <= int'(HOLD) + 1; k++)
      if (m_deb[c][k]) m_t[c] = 1'b1;
    if (clr) m_cnt[c] = 0;
    if (m_deb[c][1] && !m_deb[c][2] && m_cnt[c] < CMAX) m_cnt[c]++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Entered at a negedge; drives inputs, steps the model at the posedge,
  // compares just after it, and returns at the following negedge.
  task automatic cycle(input bit ra, input bit rb, input bit ca, input bit cb);
    raw_a = ra; raw_b = rb; clr_a = ca; clr_b = cb;
    @(posedge clk);
    model_step(0, ra, ca);
    model_step(1, rb, cb);
    #1;
    chk("model TA",    int'(ta),    int'(m_t[0]));
    chk("model TB",    int'(tb),    int'(m_t[1]));
    chk("model CNT_A", int'(cnt_a), m_cnt[0]);
    chk("model CNT_B", int'(cnt_b), m_cnt[1]);
    @(negedge clk);
  endtask

  typedef struct {
    bit ra, rb, ca, cb;
    int n;
    bit ta, tb;
    int cnta, cntb;
  } vec_t;

  function automatic vec_t mk(bit ra, bit rb, bit ca, bit cb, int n,
                              bit eta, bit etb, int eca, int ecb);
    vec_t v;
    v.ra = ra; v.rb = rb; v.ca = ca; v.cb = cb; v.n = n;
    v.ta = eta; v.tb = etb; v.cnta = eca; v.cntb = ecb;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    for (int i = 0; i < v.n; i++) cycle(v.ra, v.rb, v.ca, v.cb);
    s = $sformatf("vec%0d", idx);
    chk({s, " TA"},    int'(ta),    int'(v.ta));
    chk({s, " TB"},    int'(tb),    int'(v.tb));
    chk({s, " CNT_A"}, int'(cnt_a), v.cnta);
    chk({s, " CNT_B"}, int'(cnt_b), v.cntb);
  endtask

  vec_t tbl1[$];
  vec_t tbl2[$];

  initial begin
    int rem_a, rem_b;
    bit lvl_a, lvl_b;

    // Arrival, departure with hold, glitch, retrigger, saturation, clear+arrive.
    tbl1.push_back(mk(1,0,0,0,  6, 0,0, 0,0));
    tbl1.push_back(mk(1,0,0,0,  1, 1,0, 1,0));
    tbl1.push_back(mk(1,0,0,0, 13, 1,0, 1,0));
    tbl1.push_back(mk(0,0,0,0, 14, 1,0, 1,0));
    tbl1.push_back(mk(0,0,0,0,  1, 0,0, 1,0));
    tbl1.push_back(mk(0,1,0,0,  3, 0,0, 1,0));
    tbl1.push_back(mk(0,0,0,0, 10, 0,0, 1,0));
    tbl1.push_back(mk(0,1,0,0,  7, 0,1, 1,1));
    tbl1.push_back(mk(0,0,0,0,  8, 0,1, 1,1));
    tbl1.push_back(mk(0,1,0,0,  7, 0,1, 1,2));
    tbl1.push_back(mk(0,0,0,0, 15, 0,0, 1,2));
    tbl1.push_back(mk(0,0,1,0,  1, 0,0, 0,2));
    for (int k = 1; k <= 5; k++) begin
      tbl1.push_back(mk(1,0,0,0,  7, 1,0, (k < 3) ? k : 3, 2));
      tbl1.push_back(mk(0,0,0,0, 15, 0,0, (k < 3) ? k : 3, 2));
    end
    tbl1.push_back(mk(1,0,0,0,  6, 0,0, 3,2));
    tbl1.push_back(mk(1,0,1,0,  1, 1,0, 1,2));
    tbl1.push_back(mk(1,0,0,0,  1, 1,0, 1,2));
    tbl1.push_back(mk(0,0,0,0,  8, 1,0, 1,2));
    // After the mid-hold reset: a lone clear while occupied.
    tbl2.push_back(mk(1,0,0,0,  7, 1,0, 1,0));
    tbl2.push_back(mk(1,0,1,0,  1, 1,0, 0,0));
    tbl2.push_back(mk(1,0,0,0,  3, 1,0, 0,0));
    tbl2.push_back(mk(0,0,0,0, 15, 0,0, 0,0));

    rst_n = 1'b0;
    raw_a = 1'b0; raw_b = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset TA",    int'(ta),    0);
    chk("reset TB",    int'(tb),    0);
    chk("reset CNT_A", int'(cnt_a), 0);
    chk("reset CNT_B", int'(cnt_b), 0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl1[i]) run_vec(tbl1[i], i);

    // Asynchronous reset asserted between edges while A is holding.
    @(posedge clk);
    model_step(0, 1'b0, 1'b0);
    model_step(1, 1'b0, 1'b0);
    #1;
    chk("pre-reset TA", int'(ta), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async TA",    int'(ta),    0);
    chk("async CNT_A", int'(cnt_a), 0);
    chk("async CNT_B", int'(cnt_b), 0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0);
    chk("post-reset TA", int'(ta), 0);

    foreach (tbl2[i]) run_vec(tbl2[i], 100 + i);

    // Randomized traffic: runs of random length, including sub-debounce glitches.
    rem_a = 0; rem_b = 0; lvl_a = 1'b0; lvl_b = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (rem_a == 0) begin
        lvl_a = ~lvl_a;
        rem_a = int'($urandom_range(1, 14));
      end
      if (rem_b == 0) begin
        lvl_b = ~lvl_b;
        rem_b = int'($urandom_range(1, 14));
      end
      rem_a--;
      rem_b--;
      cycle(lvl_a, lvl_b, ($urandom_range(0, 15) == 0), ($urandom_range(0, 15) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/traffic_sensor_cond.md
Name: traffic_sensor_cond

Overview:
Conditions the two raw roadside vehicle-loop detector inputs into the clean traffic-present flags TA and TB consumed by the intersection light controller. Each channel does the following:
- synchronises the raw input to CLK;
- debounces it;
- stretches "traffic present" by a hold time after the last car leaves, so the lights do not change on short gaps between cars;
- counts vehicle arrivals for the maintenance/status interface.

Polarity: TA/TB = 1 means traffic is present on that street. The controller leaves green when the flag is 0.

Parameters:
DB_CYC, 4, consecutive synchronised cycles a raw level must be stable before it is accepted (>=1)
HOLD_CYC, 8, cycles TA/TB remain 1 after the debounced level falls (0 = no stretch)
CNT_W, 8, width of each arrival counter

Ports:
CLK  input  1  system clock
RESETB  input  1  reset
RAW_A  input  1  raw loop detector, street A, asynchronous, 1 = metal present
RAW_B  input  1  raw loop detector, street B, asynchronous
CLR_A  input  1  synchronous single-cycle clear of CNT_A
CLR_B  input  1  synchronous single-cycle clear of CNT_B
TA  output  1  traffic present on street A (registered)
TB  output  1  traffic present on street B (registered)
CNT_A  output  CNT_W  arrivals on A, saturating
CNT_B  output  CNT_W  arrivals on B, saturating

Behaviour:
- Reset: one clock, CLK. RESETB is asynchronous, active-low, and takes effect immediately, including mid-operation. It clears:
  - sync flops and debounced level to 0;
  - debounce and hold counters to 0;
  - state to IDLE;
  - TA, TB, CNT_A and CNT_B to 0.
- Channels A and B are identical and independent. The rules below are for one channel.
- Synchroniser: 2-flop chain s1 -> s2. s2 is the only signal used downstream.
- Debounce:
  - Registered level deb and counter dcnt.
  - If s2 == deb: dcnt <= 0.
  - Else if dcnt == DB_CYC-1: deb <= s2 and dcnt <= 0.
  - Else: dcnt <= dcnt+1.
  - Any s2 mismatch run shorter than DB_CYC cycles leaves deb unchanged.
- Channel FSM states: IDLE (T=0), OCC (T=1), HOLD (T=1). T is decoded from the registered state, so there is no combinational path from RAW to T.
  - IDLE -> OCC when deb=1.
  - OCC -> HOLD when deb=0 and HOLD_CYC>0; hcnt is loaded with HOLD_CYC-1.
  - OCC -> IDLE when deb=0 and HOLD_CYC=0.
  - HOLD -> OCC when deb=1. This retriggers: a new car cancels the hold.
  - HOLD -> IDLE when deb=0 and hcnt=0.
  - HOLD otherwise: hcnt <= hcnt-1.
- Latency, counting the first clock edge after RAW changes as edge 1:
  - deb changes at edge 2+DB_CYC.
  - T rises at edge 3+DB_CYC.
  - T falls at edge 3+DB_CYC+HOLD_CYC.
- Arrival counter:
  - Increments by 1 on every transition into OCC, from either IDLE or HOLD.
  - Saturates at 2^CNT_W-1 and does not wrap.
  - CLR and an arrival in the same cycle give a result of 1 (clear then count).
  - CLR alone gives 0.
- RAW toggling continuously faster than DB_CYC produces no T change and no count.

Decomposition:
- Shared defines header holds:
  - state encodings IDLE=2'b00, OCC=2'b01, HOLD=2'b10;
  - default DB_CYC/HOLD_CYC values.
- Sub-module traffic_sensor_chan contains the synchroniser, debounce, FSM, hold counter and arrival counter for one channel. The top instantiates it twice: RAW_A/CLR_A/TA/CNT_A and RAW_B/CLR_B/TB/CNT_B.
- Counter widths use a clog2 of DB_CYC and HOLD_CYC, with a minimum of 1 bit.

Test Plan:
1. Reset then clean arrival. RESETB low 3 cycles then high; RAW_A rises and holds for 20 cycles (DB_CYC=4, HOLD_CYC=8) -> TA=0 through edge 6, TA=1 from edge 7, CNT_A=1. TB=0 and CNT_B=0 throughout.
2. Departure with hold. RAW_A falls after case 1 -> TA stays 1 for 7+8=15 edges and drops at edge 15. No count change.
3. Glitch rejection and retrigger:
   - 3-cycle RAW_B pulse -> TB stays 0, CNT_B=0.
   - After a clean B arrival and departure, RAW_B returns during HOLD -> TB never drops, CNT_B increments to 2.
4. Saturation and clear:
   - CNT_W=2, five clean arrivals -> CNT_A=3.
   - CLR_A coincident with a sixth OCC entry -> CNT_A=1.
   - Lone CLR_A -> 0.
5. Async reset mid-HOLD. RESETB pulled low between clock edges while TA=1 in HOLD -> TA and CNT_A go to 0 immediately, without waiting for a clock edge. After release with RAW_A low, TA stays 0.
